// File: rtl/gpr_file.sv
// gpr_file: integer register file for the execute stage.
// Two writeback ports (ALU and long-latency/ext) with ALU priority on a
// same-address collision, two combinational read ports with same-cycle
// write bypass, and a busy-bit scoreboard for outstanding long-latency
// destinations so decode can stall on RAW/WAW hazards.
module gpr_file #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   rd_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rd_busy,

    input  logic [XLEN-1:0] alu_wb_data,
    input  logic [AW-1:0]   alu_wb_rd_addr,
    input  logic            alu_wb_rd_wr_en,

    input  logic [XLEN-1:0] ext_wb_data,
    input  logic [AW-1:0]   ext_wb_rd_addr,
    input  logic            ext_wb_rd_wr_en,

    input  logic            sb_set_en,
    input  logic [AW-1:0]   sb_set_addr,
    input  logic            sb_flush
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    logic w_alu_we;
    logic w_ext_we;

    // Effective array write enables: x0 is never written.
    always_comb begin
        w_alu_we = alu_wb_rd_wr_en && (alu_wb_rd_addr != '0);
        w_ext_we = ext_wb_rd_wr_en && (ext_wb_rd_addr != '0);
    end

    // Register array; the ALU write is issued last so it wins a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_ext_we) begin
                r_regs[ext_wb_rd_addr] <= ext_wb_data;
            end
            if (w_alu_we) begin
                r_regs[alu_wb_rd_addr] <= alu_wb_data;
            end
        end
    end

    // Scoreboard next state: ext writeback clears, a new issue sets (set wins), x0 stays clear.
    always_comb begin
        w_busy_nxt = r_busy;
        if (ext_wb_rd_wr_en) begin
            w_busy_nxt[ext_wb_rd_addr] = 1'b0;
        end
        if (sb_set_en && (sb_set_addr != '0)) begin
            w_busy_nxt[sb_set_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register; a flush drops every pending bit including a same-cycle set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else if (sb_flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Read port 1: x0, then ALU bypass, then ext bypass, then array.
    always_comb begin
        rs1_data = r_regs[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (alu_wb_rd_wr_en && (alu_wb_rd_addr == rs1_addr)) begin
            rs1_data = alu_wb_data;
        end else if (ext_wb_rd_wr_en && (ext_wb_rd_addr == rs1_addr)) begin
            rs1_data = ext_wb_data;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rs2_data = r_regs[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (alu_wb_rd_wr_en && (alu_wb_rd_addr == rs2_addr)) begin
            rs2_data = alu_wb_data;
        end else if (ext_wb_rd_wr_en && (ext_wb_rd_addr == rs2_addr)) begin
            rs2_data = ext_wb_data;
        end
    end

    // Busy outputs with the ext-writeback clear bypassed in the same cycle.
    always_comb begin
        rs1_busy = r_busy[rs1_addr] & ~(ext_wb_rd_wr_en && (ext_wb_rd_addr == rs1_addr));
        rs2_busy = r_busy[rs2_addr] & ~(ext_wb_rd_wr_en && (ext_wb_rd_addr == rs2_addr));
        rd_busy  = r_busy[rd_addr]  & ~(ext_wb_rd_wr_en && (ext_wb_rd_addr == rd_addr));
    end

endmodule

// File: doc/gpr_file.md
# gpr_file

Integer general-purpose register file for the execute stage, with a long-latency scoreboard. It receives the registered ALU writeback port and a second writeback port from the load/long-latency path. It supplies `rs1`/`rs2` operand data with same-cycle write bypass to decode (IDU1). It also tracks destination registers with an outstanding long-latency write, so decode can stall on RAW and WAW hazards.

## Interface
Parameters:
- `XLEN`, 32, register width.
- `NREG`, 32, number of architectural registers; index width is `$clog2(NREG)` (5 at the default).

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `rs1_addr` in 5: read port 1 address.
- `rs2_addr` in 5: read port 2 address.
- `rd_addr` in 5: decode destination address, used for the WAW busy check.
- `rs1_data` out XLEN: read port 1 data, combinational.
- `rs2_data` out XLEN: read port 2 data, combinational.
- `rs1_busy`, `rs2_busy`, `rd_busy` out 1: each is set when its address has a pending long-latency write.
- `alu_wb_data` in XLEN, `alu_wb_rd_addr` in 5, `alu_wb_rd_wr_en` in 1: ALU writeback port.
- `ext_wb_data` in XLEN, `ext_wb_rd_addr` in 5, `ext_wb_rd_wr_en` in 1: long-latency writeback port.
- `sb_set_en` in 1, `sb_set_addr` in 5: decode issued a long-latency op targeting `sb_set_addr`.
- `sb_flush` in 1: clear all busy bits (pipeline flush).

## Operation
- Storage is `NREG` x `XLEN` flops. Register x0 is never written and always reads 0.
- **Writes.**
  - At the edge, a port with `wr_en=1` and `addr!=0` writes its data.
  - If both ports target the same non-zero address in the same cycle, the ALU data is stored and the ext data is discarded. The busy bit is still cleared.
- **Reads.** Reads are combinational, with priority:
  - address 0 → 0;
  - else ALU port writing the same address this cycle → `alu_wb_data`;
  - else ext port writing the same address → `ext_wb_data`;
  - else array contents.
- **Scoreboard.** One busy bit per register; `busy[0]` is hardwired 0.
  - **Set:** `sb_set_en & sb_set_addr!=0` sets `busy[sb_set_addr]` at the edge.
  - **Clear:** `ext_wb_rd_wr_en` clears `busy[ext_wb_rd_addr]` at the edge. ALU writes do not touch busy bits.
  - **Set and clear to the same address in the same cycle:** set wins, because a new op was issued.
  - **Flush:** `sb_flush` clears all bits at the edge and overrides a same-cycle set. Ext writes in a flush cycle still update the array.
- **Busy outputs.** `rsN_busy` = `busy[rsN_addr] & ~(ext_wb_rd_wr_en & ext_wb_rd_addr==rsN_addr)`, i.e. the clear is bypassed like the data. `rd_busy` uses the same form on `rd_addr`.
- **During reset.** While `rst` is high, all writes and set/flush inputs are ignored.

## Timing
- **Reset.** Asserting `rst` asynchronously zeroes every register and every busy bit. Read data then equals the bypass value if a write is presented, otherwise 0.
- **Read latency.** 0 cycles; a value written at edge N is visible from the array from cycle N+1. In cycle N it is visible through the bypass.
- **Busy latency.** Busy is visible on `rsN_busy` the cycle after `sb_set_en`. It drops in the same cycle that `ext_wb_rd_wr_en` presents the matching address.
- **Deassertion.** Deassertion of `rst` is synchronous to `clk` upstream. The first write is accepted at the first edge with `rst` low.
- **Reset mid-operation.** Pending busy bits are lost. An ext writeback arriving after reset writes the array; its clear of an already-zero bit is a no-op.

## Test plan
- **Reset.** Preload x5=0x1234 then pulse `rst` mid-cycle. Expected: `rs1_data` at `rs1_addr`=5 reads 0 immediately, before the next edge; all busy outputs are 0.
- **ALU write and x0.**
  - ALU writes x7=0xDEADBEEF; the same cycle `rs2_addr`=7 reads 0xDEADBEEF via bypass, and the next cycle reads it from the array.
  - An ALU write to x0 of 0xFFFFFFFF leaves `rs1_addr`=0 reading 0.
- **Dual-port collision.** ALU x3=0x11 and ext x3=0x22 in the same cycle. Expected: same-cycle read is 0x11; next cycle reads 0x11.
- **Scoreboard lifecycle.**
  - `sb_set_en` x9, then `rs1_addr`=9 and `rd_addr`=9. Expected: `rs1_busy` and `rd_busy` are 1 from the next cycle.
  - Ext writes x9=0xCAFE after 4 cycles. Expected: busy reads 0 and `rs1_data`=0xCAFE that cycle; busy stays 0 after.
- **Set/clear race.** With x4 busy, the ext write to x4 and `sb_set_en` x4 occur in the same cycle. Expected: the next cycle `rs1_busy`=1 and the data is the ext value. `sb_set_en` x0 never raises busy.
- **Flush.**
  - Set x10 and x11 busy, then `sb_flush` together with `sb_set_en` x12. Expected: the next cycle all three read not busy.
  - An ext write x10=0x55 in the flush cycle lands in the array.
